// File: rtl/uart_rx_deser_if.sv
// Receive-FIFO read port of uart_rx_deser: head byte, valid, occupancy and pop.
interface uart_rx_deser_if #(
    parameter int DEPTH = 4
);
    logic [7:0]              o_dat;
    logic                    o_vld;
    logic [$clog2(DEPTH):0]  o_cnt;
    logic                    i_pop;

    modport slave  (output o_dat, output o_vld, output o_cnt, input  i_pop);
    modport master (input  o_dat, input  o_vld, input  o_cnt, output i_pop);
endinterface

// File: rtl/uart_rx_deser.sv
// UART receiver: 16x oversampled 8-bit frames with optional parity, feeding a
// small receive FIFO with sticky framing/parity/overrun flags.
module uart_rx_deser #(
    parameter int DEPTH    = 4,
    parameter int SYNC_STG = 2
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  i_rxd,
    input  logic [7:0]            r_baud_div,
    input  logic                  r_par_en,
    input  logic                  r_par_odd,
    input  logic                  i_clr,
    uart_rx_deser_if.slave        fifo,
    output logic                  o_busy,
    output logic                  o_ferr,
    output logic                  o_perr,
    output logic                  o_ovr
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [SYNC_STG-1:0] sync_q;
    logic                rxd_s;
    state_t              state_q;
    logic [7:0]          tick_cnt_q;
    logic                tick;
    logic [3:0]          samp_q;
    logic [2:0]          bitn_q;
    logic [7:0]          shift_q;
    logic                par_bad_q;
    logic                push_q;
    logic                arm_q;
    logic                ferr_q;
    logic                perr_q;
    logic                ovr_q;

    logic [7:0]          mem_q [DEPTH];
    logic [CNT_W-1:0]    wp_q;
    logic [CNT_W-1:0]    rp_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                full_d;
    logic                empty_d;
    logic                do_pop_d;
    logic                do_push_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= i_rxd;
            for (int unsigned i = 1; i < SYNC_STG; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rxd_s = sync_q[SYNC_STG-1];
    assign tick  = (state_q != IDLE) && (tick_cnt_q >= r_baud_div);

    always_ff @(posedge clk) begin
        if (srst || state_q == IDLE || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
        end
    end

    // arm_q blocks a new start after a framing error until the line has been seen high.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= IDLE;
            samp_q    <= '0;
            bitn_q    <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            push_q    <= 1'b0;
            arm_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            ferr_q <= ferr_q & ~i_clr;
            perr_q <= perr_q & ~i_clr;
            if (rxd_s) begin
                arm_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!rxd_s && arm_q) begin
                        state_q   <= START;
                        samp_q    <= '0;
                        par_bad_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (samp_q == 4'd7) begin
                            samp_q  <= '0;
                            bitn_q  <= '0;
                            state_q <= rxd_s ? IDLE : DATA;
                        end else begin
                            samp_q <= samp_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            shift_q <= {rxd_s, shift_q[7:1]};
                            bitn_q  <= bitn_q + 3'd1;
                            if (bitn_q == 3'd7) begin
                                state_q <= r_par_en ? PARITY : STOP;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            par_bad_q <= (rxd_s != ((^shift_q) ^ r_par_odd));
                            state_q   <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            state_q <= IDLE;
                            if (rxd_s) begin
                                if (par_bad_q) begin
                                    perr_q <= 1'b1;
                                end else begin
                                    push_q <= 1'b1;
                                end
                            end else begin
                                ferr_q <= 1'b1;
                                arm_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cnt_d     = wp_q - rp_q;
    assign full_d    = (cnt_d == CNT_W'(DEPTH));
    assign empty_d   = (cnt_d == '0);
    assign do_pop_d  = fifo.i_pop && !empty_d;
    assign do_push_d = push_q && (!full_d || do_pop_d);

    always_ff @(posedge clk) begin
        if (srst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (do_push_d) begin
                wp_q <= wp_q + 1'b1;
            end
            if (do_pop_d) begin
                rp_q <= rp_q + 1'b1;
            end
            ovr_q <= (ovr_q & ~i_clr) | (push_q && full_d && !do_pop_d);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_d) begin
            mem_q[wp_q[AW-1:0]] <= shift_q;
        end
    end

    assign fifo.o_dat = empty_d ? '0 : mem_q[rp_q[AW-1:0]];
    assign fifo.o_vld = !empty_d;
    assign fifo.o_cnt = cnt_d;
    assign o_busy     = (state_q != IDLE);
    assign o_ferr     = ferr_q;
    assign o_perr     = perr_q;
    assign o_ovr      = ovr_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: a scoreboard queue holds expected bytes and a
// monitor checks each byte the bench pops; flag/occupancy checks run inline.
module tb_uart_rx_deser;
    logic       clk = 1'b0;
    logic       srst;
    logic       rxd;
    logic [7:0] baud;
    logic       par_en;
    logic       par_odd;
    logic       clr;
    logic       busy, ferr, perr, ovr;

    int         total = 0;
    int         bad   = 0;
    int         bitlen;
    logic [7:0] exp_q [$];

    uart_rx_deser_if #(.DEPTH(4)) fifo_if ();

    uart_rx_deser #(.DEPTH(4), .SYNC_STG(2)) dut (
        .clk        (clk),
        .srst       (srst),
        .i_rxd      (rxd),
        .r_baud_div (baud),
        .r_par_en   (par_en),
        .r_par_odd  (par_odd),
        .i_clr      (clr),
        .fifo       (fifo_if),
        .o_busy     (busy),
        .o_ferr     (ferr),
        .o_perr     (perr),
        .o_ovr      (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * bitlen) @(negedge clk);
    endtask

    // Drives one frame starting on a falling clock edge; leaves rxd at the stop value.
    task automatic send(input logic [7:0] b, input logic par, input logic stopb, input bit exp_push);
        if (exp_push) exp_q.push_back(b);
        @(negedge clk);
        rxd = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_bits(1);
        end
        if (par_en) begin
            rxd = par;
            wait_bits(1);
        end
        rxd = stopb;
        wait_bits(1);
        if (stopb) repeat (16) @(negedge clk);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fifo_if.i_pop = 1'b1;
            @(negedge clk);
            fifo_if.i_pop = 1'b0;
        end
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted pop must present the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (fifo_if.i_pop && fifo_if.o_vld) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", {24'd0, fifo_if.o_dat}, 32'hFFFF_FFFF);
                end else begin
                    chk("pop_data", {24'd0, fifo_if.o_dat}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit busy_seen;
        int k;
        srst = 1'b1;
        rxd = 1'b1;
        baud = 8'd2;
        par_en = 1'b0;
        par_odd = 1'b0;
        clr = 1'b0;
        fifo_if.i_pop = 1'b0;
        bitlen = 16 * (2 + 1);
        repeat (3) @(posedge clk);
        settle();
        chk("rst_vld", {31'd0, fifo_if.o_vld}, 32'd0);
        chk("rst_cnt", {29'd0, fifo_if.o_cnt}, 32'd0);
        chk("rst_dat", {24'd0, fifo_if.o_dat}, 32'd0);
        chk("rst_flags", {28'd0, busy, ferr, perr, ovr}, 32'd0);
        srst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 byte, then pop back to empty
        send(8'hA5, 1'b0, 1'b1, 1'b1);
        settle();
        chk("a5_vld", {31'd0, fifo_if.o_vld}, 32'd1);
        chk("a5_dat", {24'd0, fifo_if.o_dat}, 32'hA5);
        chk("a5_cnt", {29'd0, fifo_if.o_cnt}, 32'd1);
        pop_n(1);
        settle();
        chk("a5_empty_vld", {31'd0, fifo_if.o_vld}, 32'd0);
        chk("a5_empty_dat", {24'd0, fifo_if.o_dat}, 32'd0);

        // 4-tick low glitch is rejected silently
        @(negedge clk);
        rxd = 1'b0;
        repeat (4 * 3) @(negedge clk);
        rxd = 1'b1;
        wait_bits(2);
        settle();
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_cnt", {29'd0, fifo_if.o_cnt}, 32'd0);
        chk("glitch_flags", {29'd0, ferr, perr, ovr}, 32'd0);

        // even parity: 0x03 needs parity 0
        par_en = 1'b1;
        par_odd = 1'b0;
        send(8'h03, 1'b1, 1'b1, 1'b0);
        settle();
        chk("par_bad_perr", {31'd0, perr}, 32'd1);
        chk("par_bad_cnt", {29'd0, fifo_if.o_cnt}, 32'd0);
        send(8'h03, 1'b0, 1'b1, 1'b1);
        settle();
        chk("par_good_cnt", {29'd0, fifo_if.o_cnt}, 32'd1);
        chk("perr_sticky", {31'd0, perr}, 32'd1);
        pop_n(1);
        clr_pulse();
        chk("perr_clr", {31'd0, perr}, 32'd0);
        // odd parity: 0x01 needs parity 0
        par_odd = 1'b1;
        send(8'h01, 1'b0, 1'b1, 1'b1);
        settle();
        chk("odd_good_perr", {31'd0, perr}, 32'd0);
        pop_n(1);
        par_en = 1'b0;
        par_odd = 1'b0;

        // framing error, line held low afterwards must not start a frame
        send(8'h5A, 1'b0, 1'b0, 1'b0);
        busy_seen = 1'b0;
        for (int i = 0; i < 3 * bitlen; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        chk("ferr_set", {31'd0, ferr}, 32'd1);
        chk("ferr_cnt", {29'd0, fifo_if.o_cnt}, 32'd0);
        chk("ferr_low_no_frame", {31'd0, busy_seen}, 32'd0);
        rxd = 1'b1;
        wait_bits(1);
        send(8'h3C, 1'b0, 1'b1, 1'b1);
        settle();
        chk("ferr_recover_cnt", {29'd0, fifo_if.o_cnt}, 32'd1);
        pop_n(1);
        clr_pulse();
        chk("ferr_clr", {31'd0, ferr}, 32'd0);

        // overrun: fifth byte dropped
        for (int b = 1; b <= 5; b++) send(8'(b), 1'b0, 1'b1, b <= 4);
        settle();
        chk("ovr_cnt", {29'd0, fifo_if.o_cnt}, 32'd4);
        chk("ovr_set", {31'd0, ovr}, 32'd1);
        pop_n(4);
        settle();
        chk("ovr_drain_vld", {31'd0, fifo_if.o_vld}, 32'd0);
        clr_pulse();
        chk("ovr_clr", {31'd0, ovr}, 32'd0);

        // pop coinciding with the push into a full FIFO
        for (int b = 1; b <= 4; b++) send(8'(b), 1'b0, 1'b1, 1'b1);
        fork
            send(8'h05, 1'b0, 1'b1, 1'b1);
            begin
                k = 0;
                while (!busy && k < 4000) begin @(negedge clk); k++; end
                while (busy && k < 4000) begin @(negedge clk); k++; end
                chk("coinc_busy_fall", {31'd0, busy}, 32'd0);
                fifo_if.i_pop = 1'b1;
                @(negedge clk);
                fifo_if.i_pop = 1'b0;
            end
        join
        settle();
        chk("coinc_ovr", {31'd0, ovr}, 32'd0);
        chk("coinc_cnt", {29'd0, fifo_if.o_cnt}, 32'd4);
        pop_n(4);

        // reset in the middle of 0x77's data bits
        @(negedge clk);
        rxd = 1'b0;
        wait_bits(1);
        rxd = 1'b1;
        wait_bits(3);
        chk("mid_frame_busy", {31'd0, busy}, 32'd1);
        srst = 1'b1;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        settle();
        chk("rst_abort_busy", {31'd0, busy}, 32'd0);
        wait_bits(2);
        send(8'h11, 1'b0, 1'b1, 1'b1);
        settle();
        chk("post_rst_cnt", {29'd0, fifo_if.o_cnt}, 32'd1);
        chk("post_rst_flags", {29'd0, ferr, perr, ovr}, 32'd0);
        pop_n(1);
        settle();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
